me_window_loader: RTL and testbench
===================================

Name: me_window_loader

Overview:
Upstream sequencer for the full-search motion estimator (16x16 reference block, 32x32 search window).
- Accepts a raw 8-bit pixel stream: 256 reference pixels, then 1024 search-window pixels.
- Writes them into the estimator's R and S memories, then asserts start and holds it until completed.
- Captures motionX/motionY/BestDist, converts the vectors to signed, and presents the result on a valid/ready output port.

Parameters:
REF_PIXELS, 256, reference block pixels (16x16); write address width = clog2(REF_PIXELS)=8
SRCH_PIXELS, 1024, search window pixels (32x32); write address width = clog2(SRCH_PIXELS)=10
PIX_W, 8, pixel width
TIMEOUT_CYCLES, 4200, maximum RUN cycles before declaring timeout (estimator nominally needs 4112)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  pixel beat valid
in_ready  out  1  loader accepts pixel this cycle
in_data  in  PIX_W  pixel value
ref_we  out  1  reference memory write enable
ref_waddr  out  8  reference memory write address
ref_wdata  out  PIX_W  reference memory write data
srch_we  out  1  search memory write enable
srch_waddr  out  10  search memory write address
srch_wdata  out  PIX_W  search memory write data
me_start  out  1  estimator start, level
me_completed  in  1  estimator done
me_motionX  in  4  raw X vector, two's complement
me_motionY  in  4  raw Y vector, two's complement
me_bestdist  in  8  best SAD distance (8'hFF = no match)
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_mvx  out  5  signed X vector, -8..+7
res_mvy  out  5  signed Y vector, -8..+7
res_bestdist  out  8  captured BestDist
res_nomatch  out  1  captured BestDist == 8'hFF
res_timeout  out  1  estimator did not complete in time
busy  out  1  high in any state other than LOAD_REF with beat count 0

Behaviour:
Reset values and reset handling:
- Reset (reset=0, asynchronous): state=LOAD_REF, beat count=0, RUN timer=0.
- Outputs at reset: in_ready=0 while reset is asserted, then 1 from the first clock after release. All other outputs 0.
- Memories are not cleared.
- Reset mid-operation aborts everything. No partial result is emitted, and the next accepted beat goes to ref address 0.

State machine:
- LOAD_REF: in_ready=1. Each accepted beat (in_valid&in_ready) writes ref[count]; count++. After accepting beat 255, count wraps to 0 and state goes to LOAD_SRCH.
- LOAD_SRCH: in_ready=1. Each accepted beat writes srch[count]. After accepting beat 1023, state goes to RUN.
- RUN: in_ready=0. me_start=1 from the first RUN cycle. The timer increments every RUN cycle.
  - If me_completed=1 is sampled: capture the vector, bestdist and nomatch; res_timeout=0; go to HOLD.
  - Else if the timer reaches TIMEOUT_CYCLES-1: capture mv=0, bestdist=8'hFF, nomatch=1, timeout=1; go to HOLD.
  - me_start drops on the same edge as either capture.
- HOLD: in_ready=0, res_valid=1, result outputs stable. When res_valid&res_ready, go to LOAD_REF with res_valid=0 the next cycle.

Memory write timing:
- Write outputs are registered: an accept at edge t drives we/addr/data for exactly one cycle after edge t.
- ref_we and srch_we are never high in the same cycle.
- The last srch_we (addr 1023) coincides with the first me_start cycle. The estimator samples start no earlier than the following edge.

Arithmetic and other rules:
- Sign conversion: res_mv = raw>=8 ? raw-16 : raw. This is a sign-extension of 4 bits to 5.
- me_completed outside RUN is ignored. Completed and timeout on the same edge: completed wins.
- in_valid with in_ready=0 has no effect, and in_data is not sampled.
- busy=0 only in LOAD_REF with count 0.

Decomposition:
- Package me_pkg holds:
  - Constants REF_PIXELS, SRCH_PIXELS, PIX_W and the derived address widths.
  - Enum loader_state_t {LOAD_REF, LOAD_SRCH, RUN, HOLD}.
  - Struct me_result_t {mvx, mvy, bestdist, nomatch, timeout}.
- One sub-module: me_run_timer (clear/enable counter with a terminal-count flag). Everything else stays in the top.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0 while in reset; in_ready=1 on the first cycle after release; busy=0.
2. 1280 continuous beats with data=index[7:0] -> ref_waddr 0..255 carrying data 0..255, then srch_waddr 0..1023 carrying data 0..255 repeating. me_start rises in the same cycle as srch_we for addr 1023. in_ready=0 afterwards.
3. in_valid toggled 1,0,0,1 repeating over the load -> exactly 1280 writes with contiguous addresses; no write in cycles without an accept.
4. After load, me_completed pulsed with motionX=4'hD, motionY=4'h3, bestdist=8'h00 -> res_mvx=-3, res_mvy=+3, res_nomatch=0, res_timeout=0. With res_ready low for 5 cycles the outputs stay stable; res_ready=1 returns the block to LOAD_REF.
5. me_completed never asserted -> after 4200 RUN cycles: res_valid=1, res_timeout=1, res_bestdist=8'hFF, res_nomatch=1, mv=0; me_start=0.
6. reset asserted at search beat 500 -> outputs are 0 asynchronously; after release, the first accepted beat appears on ref_waddr=0 and no res_valid is produced.

Source files
------------

// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg
// Shared constants and types for the motion-estimator window loader.
//   REF_PIXELS / SRCH_PIXELS : pixel counts of the 16x16 reference block and
//                              the 32x32 search window
//   PIX_W                    : pixel width
//   REF_AW / SRCH_AW         : write address widths of the R and S memories
//   loader_state_t           : loader sequencing states
//   me_result_t              : captured estimator result
// ---------------------------------------------------------------------------
package me_pkg;

  localparam int REF_PIXELS  = 256;
  localparam int SRCH_PIXELS = 1024;
  localparam int PIX_W       = 8;
  localparam int REF_AW      = $clog2(REF_PIXELS);
  localparam int SRCH_AW     = $clog2(SRCH_PIXELS);
  localparam int MV_RAW_W    = 4;
  localparam int MV_W        = 5;
  localparam int DIST_W      = 8;

  // BestDist value the estimator reports when no candidate matched.
  localparam logic [DIST_W-1:0] NO_MATCH_DIST = 8'hFF;

  typedef enum logic [1:0] {
    LOAD_REF  = 2'd0,
    LOAD_SRCH = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } loader_state_t;

  typedef struct packed {
    logic signed [MV_W-1:0] mvx;
    logic signed [MV_W-1:0] mvy;
    logic [DIST_W-1:0]      bestdist;
    logic                   nomatch;
    logic                   timeout;
  } me_result_t;

endpackage

// File: rtl/me_run_timer.sv
// ---------------------------------------------------------------------------
// me_run_timer
// Counts estimator RUN cycles and flags the last permitted cycle.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   clr_i  : synchronous clear (takes priority over enable)
//   en_i   : count this cycle
//   tc_o   : high while enabled and the count sits at CYCLES-1
// ---------------------------------------------------------------------------
module me_run_timer
  import me_pkg::*;
#(
  parameter int CYCLES = 4200
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int            W    = $clog2(CYCLES);
  localparam logic [W-1:0]  LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/me_window_loader.sv
// ---------------------------------------------------------------------------
// me_window_loader
// Loads a reference block and a search window from a pixel stream into the
// motion estimator's memories, runs the estimator, and hands its (sign-
// converted) result downstream over a valid/ready port.
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : pixel stream (256 ref pixels, then 1024 search)
//   ref_we/ref_waddr/ref_wdata    : registered R-memory write port
//   srch_we/srch_waddr/srch_wdata : registered S-memory write port
//   me_start      : level start, held until completion or timeout
//   me_completed, me_motionX/Y, me_bestdist : estimator result inputs
//   res_valid/res_ready, res_mvx/mvy, res_bestdist, res_nomatch, res_timeout
//                 : captured result port
//   busy          : low only when idle in LOAD_REF with nothing accepted yet
// ---------------------------------------------------------------------------
module me_window_loader
  import me_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4200
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_data,
  output logic                     ref_we,
  output logic [REF_AW-1:0]        ref_waddr,
  output logic [PIX_W-1:0]         ref_wdata,
  output logic                     srch_we,
  output logic [SRCH_AW-1:0]       srch_waddr,
  output logic [PIX_W-1:0]         srch_wdata,
  output logic                     me_start,
  input  logic                     me_completed,
  input  logic [MV_RAW_W-1:0]      me_motionX,
  input  logic [MV_RAW_W-1:0]      me_motionY,
  input  logic [DIST_W-1:0]        me_bestdist,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [MV_W-1:0]   res_mvx,
  output logic signed [MV_W-1:0]   res_mvy,
  output logic [DIST_W-1:0]        res_bestdist,
  output logic                     res_nomatch,
  output logic                     res_timeout,
  output logic                     busy
);

  localparam logic [SRCH_AW-1:0] REF_LAST  = SRCH_AW'(REF_PIXELS - 1);
  localparam logic [SRCH_AW-1:0] SRCH_LAST = SRCH_AW'(SRCH_PIXELS - 1);

  // Two's-complement 4-bit vector to signed 5-bit: raw>=8 maps to raw-16.
  function automatic logic signed [MV_W-1:0] sext_mv(input logic [MV_RAW_W-1:0] raw);
    return $signed({raw[MV_RAW_W-1], raw});
  endfunction

  loader_state_t          state_q, state_d;
  logic [SRCH_AW-1:0]     cnt_q, cnt_d;
  me_result_t             res_q, res_d;
  logic                   alive_q;
  logic                   ref_we_q, ref_we_d;
  logic [REF_AW-1:0]      ref_waddr_q, ref_waddr_d;
  logic [PIX_W-1:0]       ref_wdata_q, ref_wdata_d;
  logic                   srch_we_q, srch_we_d;
  logic [SRCH_AW-1:0]     srch_waddr_q, srch_waddr_d;
  logic [PIX_W-1:0]       srch_wdata_q, srch_wdata_d;
  logic                   accept;
  logic                   in_run;
  logic                   timer_tc;

  // alive_q keeps in_ready low while reset is asserted and lets it rise on
  // the first clock after release, even though the state is already LOAD_REF.
  assign in_ready = alive_q && ((state_q == LOAD_REF) || (state_q == LOAD_SRCH));
  assign accept   = in_valid && in_ready;
  assign in_run   = (state_q == RUN);

  me_run_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clr_i (!in_run),
    .en_i  (in_run),
    .tc_o  (timer_tc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    ref_we_d     = 1'b0;
    ref_waddr_d  = ref_waddr_q;
    ref_wdata_d  = ref_wdata_q;
    srch_we_d    = 1'b0;
    srch_waddr_d = srch_waddr_q;
    srch_wdata_d = srch_wdata_q;

    case (state_q)
      LOAD_REF: begin
        if (accept) begin
          ref_we_d    = 1'b1;
          ref_waddr_d = cnt_q[REF_AW-1:0];
          ref_wdata_d = in_data;
          if (cnt_q == REF_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_SRCH;
          end else begin
            cnt_d = cnt_q + SRCH_AW'(1);
          end
        end
      end
      LOAD_SRCH: begin
        if (accept) begin
          srch_we_d    = 1'b1;
          srch_waddr_d = cnt_q;
          srch_wdata_d = in_data;
          if (cnt_q == SRCH_LAST) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + SRCH_AW'(1);
          end
        end
      end
      RUN: begin
        // A completion on the terminal cycle still beats the timeout.
        if (me_completed) begin
          res_d.mvx      = sext_mv(me_motionX);
          res_d.mvy      = sext_mv(me_motionY);
          res_d.bestdist = me_bestdist;
          res_d.nomatch  = (me_bestdist == NO_MATCH_DIST);
          res_d.timeout  = 1'b0;
          state_d        = HOLD;
        end else if (timer_tc) begin
          res_d.mvx      = '0;
          res_d.mvy      = '0;
          res_d.bestdist = NO_MATCH_DIST;
          res_d.nomatch  = 1'b1;
          res_d.timeout  = 1'b1;
          state_d        = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          cnt_d   = '0;
          state_d = LOAD_REF;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = LOAD_REF;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD_REF;
      cnt_q        <= '0;
      res_q        <= '0;
      alive_q      <= 1'b0;
      ref_we_q     <= 1'b0;
      ref_waddr_q  <= '0;
      ref_wdata_q  <= '0;
      srch_we_q    <= 1'b0;
      srch_waddr_q <= '0;
      srch_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      alive_q      <= 1'b1;
      ref_we_q     <= ref_we_d;
      ref_waddr_q  <= ref_waddr_d;
      ref_wdata_q  <= ref_wdata_d;
      srch_we_q    <= srch_we_d;
      srch_waddr_q <= srch_waddr_d;
      srch_wdata_q <= srch_wdata_d;
    end
  end

  assign ref_we       = ref_we_q;
  assign ref_waddr    = ref_waddr_q;
  assign ref_wdata    = ref_wdata_q;
  assign srch_we      = srch_we_q;
  assign srch_waddr   = srch_waddr_q;
  assign srch_wdata   = srch_wdata_q;
  assign me_start     = in_run;
  assign res_valid    = (state_q == HOLD);
  assign res_mvx      = res_q.mvx;
  assign res_mvy      = res_q.mvy;
  assign res_bestdist = res_q.bestdist;
  assign res_nomatch  = res_q.nomatch;
  assign res_timeout  = res_q.timeout;
  assign busy         = !((state_q == LOAD_REF) && (cnt_q == '0));

endmodule

// File: tb/tb_me_window_loader.sv
module tb_me_window_loader;

  localparam int TO     = 4200;
  localparam int N_REF  = 256;
  localparam int N_LOAD = 1280;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        ref_we;
  logic [7:0]  ref_waddr;
  logic [7:0]  ref_wdata;
  logic        srch_we;
  logic [9:0]  srch_waddr;
  logic [7:0]  srch_wdata;
  logic        me_start;
  logic        me_completed = 1'b0;
  logic [3:0]  me_motionX = 4'h0;
  logic [3:0]  me_motionY = 4'h0;
  logic [7:0]  me_bestdist = 8'h00;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic signed [4:0] res_mvx;
  logic signed [4:0] res_mvy;
  logic [7:0]  res_bestdist;
  logic        res_nomatch;
  logic        res_timeout;
  logic        busy;

  always #5 clock = ~clock;

  me_window_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .ref_we       (ref_we),
    .ref_waddr    (ref_waddr),
    .ref_wdata    (ref_wdata),
    .srch_we      (srch_we),
    .srch_waddr   (srch_waddr),
    .srch_wdata   (srch_wdata),
    .me_start     (me_start),
    .me_completed (me_completed),
    .me_motionX   (me_motionX),
    .me_motionY   (me_motionY),
    .me_bestdist  (me_bestdist),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_mvx      (res_mvx),
    .res_mvy      (res_mvy),
    .res_bestdist (res_bestdist),
    .res_nomatch  (res_nomatch),
    .res_timeout  (res_timeout),
    .busy         (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { bit s; int addr; int data; } wr_t;
  wr_t exp_q[$];
  wr_t obs_q[$];

  // Monitor state (written only by the monitor processes).
  int   cyc_g = 0;
  int   last_wr_cyc = -1;
  int   rise_cyc = -1;
  int   both_cnt = 0;
  int   rv_cnt = 0;
  logic start_d = 1'b0;

  // Per-load snapshots (written only by the stimulus tasks).
  int ld_obs_base = 0;
  int ld_cyc_base = 0;
  int ld_both_base = 0;

  // Expected result of the current run.
  int e_mvx, e_mvy, e_bd;
  bit e_nm, e_to;

  always @(posedge clock) cyc_g <= cyc_g + 1;

  always @(negedge clock) begin
    if (ref_we === 1'b1) obs_q.push_back(wr_t'{1'b0, int'(ref_waddr), int'(ref_wdata)});
    if (srch_we === 1'b1) begin
      obs_q.push_back(wr_t'{1'b1, int'(srch_waddr), int'(srch_wdata)});
      if (srch_waddr == 10'd1023) last_wr_cyc <= cyc_g;
    end
    if (ref_we === 1'b1 && srch_we === 1'b1) both_cnt <= both_cnt + 1;
    if (me_start === 1'b1 && start_d === 1'b0) rise_cyc <= cyc_g;
    start_d <= me_start;
    if (res_valid === 1'b1) rv_cnt <= rv_cnt + 1;
  end

  function automatic logic [59:0] all_outs();
    return {in_ready, ref_we, ref_waddr, ref_wdata, srch_we, srch_waddr, srch_wdata,
            me_start, res_valid, res_mvx, res_mvy, res_bestdist, res_nomatch,
            res_timeout, busy};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_tests++;
      if (all_outs() !== 60'd0) begin
        n_fail++;
        $display("FAIL reset_outs cycle %0d: got %h expected 0", i, all_outs());
      end
    end
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if ({in_ready, busy, me_start, res_valid, ref_we, srch_we} !== 6'b100000) begin
      n_fail++;
      $display("FAIL post_release: ready/busy/start/valid/rwe/swe got %b expected 100000",
               {in_ready, busy, me_start, res_valid, ref_we, srch_we});
    end
  endtask

  // mode 0: continuous, data = beat index; mode 1: valid 1,0,0,1 repeating;
  // mode 2: random valid. Modes 1/2 also wiggle me_completed (must be ignored).
  task automatic do_load(input int mode, input int n);
    int acc = 0;
    int cyc = 0;
    logic v;
    logic [7:0] d;
    exp_q.delete();
    ld_obs_base  = obs_q.size();
    ld_cyc_base  = cyc_g;
    ld_both_base = both_cnt;
    while (acc < n && cyc < 20000) begin
      @(negedge clock);
      cyc++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: v = ($urandom_range(2, 0) != 0);
      endcase
      d = (mode == 0) ? acc[7:0] : 8'($urandom);
      in_valid = v;
      in_data = d;
      me_completed = (mode != 0) && ($urandom_range(7, 0) == 0);
      me_motionX = 4'($urandom);
      me_motionY = 4'($urandom);
      me_bestdist = 8'($urandom);
      if (v && in_ready === 1'b1) begin
        exp_q.push_back(wr_t'{acc >= N_REF, (acc >= N_REF) ? acc - N_REF : acc, int'(d)});
        acc++;
      end
    end
    n_tests++;
    if (acc != n) begin
      n_fail++;
      $display("FAIL load_accept: got %0d beats expected %0d", acc, n);
    end
    @(negedge clock);
    in_valid = 1'b0;
    me_completed = 1'b0;
  endtask

  // complete_at: RUN cycle (1-based) on which me_completed is pulsed; 0 = never.
  task automatic run_phase(input int complete_at, input logic [3:0] mx,
                           input logic [3:0] my, input logic [7:0] bd);
    int c = 0;
    int rdy_bad = 0;
    bit done = 0;
    bit comp;
    logic [23:0] exp_v;
    for (int i = 0; i < 6000; i++) begin
      if (me_start !== 1'b1) begin
        done = 1;
        break;
      end
      c++;
      if (in_ready !== 1'b0) rdy_bad++;
      me_completed = (c == complete_at);
      me_motionX = (c == complete_at) ? mx : 4'($urandom);
      me_motionY = (c == complete_at) ? my : 4'($urandom);
      me_bestdist = (c == complete_at) ? bd : 8'($urandom);
      in_valid = 1'($urandom_range(1, 0));
      in_data = 8'($urandom);
      @(negedge clock);
    end
    me_completed = 1'b0;
    in_valid = 1'b0;
    comp = (complete_at >= 1) && (complete_at <= TO);
    e_mvx = comp ? ((int'(mx) >= 8) ? int'(mx) - 16 : int'(mx)) : 0;
    e_mvy = comp ? ((int'(my) >= 8) ? int'(my) - 16 : int'(my)) : 0;
    e_bd  = comp ? int'(bd) : 255;
    e_nm  = (e_bd == 255);
    e_to  = !comp;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL run_end: me_start still high after %0d cycles", c);
    end
    n_tests++;
    if (c != (comp ? complete_at : TO)) begin
      n_fail++;
      $display("FAIL run_len: got %0d start cycles expected %0d", c, comp ? complete_at : TO);
    end
    n_tests++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL run_ready: in_ready high in %0d RUN cycles expected 0", rdy_bad);
    end
    exp_v = {1'b1, 5'(e_mvx), 5'(e_mvy), 8'(e_bd), e_nm, e_to, 3'b0};
    n_tests++;
    if ({res_valid, res_mvx, res_mvy, res_bestdist, res_nomatch, res_timeout, 3'b0} !== exp_v) begin
      n_fail++;
      $display("FAIL result: got valid=%b mvx=%0d mvy=%0d bd=%h nm=%b to=%b expected valid=1 mvx=%0d mvy=%0d bd=%h nm=%b to=%b",
               res_valid, res_mvx, res_mvy, res_bestdist, res_nomatch, res_timeout,
               e_mvx, e_mvy, e_bd, e_nm, e_to);
    end
  endtask

  task automatic hold_phase(input int n);
    logic [23:0] exp_v;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 5'(e_mvx), 5'(e_mvy), 8'(e_bd), e_nm, e_to};
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if ({res_valid, me_start, in_ready, busy, res_mvx, res_mvy, res_bestdist,
           res_nomatch, res_timeout} !== exp_v) begin
        n_fail++;
        $display("FAIL hold_stable cycle %0d: got %h expected %h", i,
                 {res_valid, me_start, in_ready, busy, res_mvx, res_mvy, res_bestdist,
                  res_nomatch, res_timeout}, exp_v);
      end
      me_completed = 1'($urandom_range(1, 0));
      me_motionX = 4'($urandom);
      me_motionY = 4'($urandom);
      me_bestdist = 8'($urandom);
      in_valid = 1'($urandom_range(1, 0));
      res_ready = 1'b0;
      @(negedge clock);
    end
    me_completed = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    n_tests++;
    if ({res_valid, in_ready, busy, me_start} !== 4'b0100) begin
      n_fail++;
      $display("FAIL hold_release: valid/ready/busy/start got %b expected 0100",
               {res_valid, in_ready, busy, me_start});
    end
  endtask

  task automatic check_writes();
    int bad = -1;
    n_tests++;
    if (obs_q.size() - ld_obs_base != exp_q.size()) begin
      n_fail++;
      $display("FAIL write_count: got %0d expected %0d", obs_q.size() - ld_obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (ld_obs_base + i >= obs_q.size()) begin
        bad = i;
        break;
      end
      if (obs_q[ld_obs_base + i].s != exp_q[i].s ||
          obs_q[ld_obs_base + i].addr != exp_q[i].addr ||
          obs_q[ld_obs_base + i].data != exp_q[i].data) begin
        bad = i;
        break;
      end
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      if (ld_obs_base + bad < obs_q.size())
        $display("FAIL write_seq at %0d: got srch=%0d addr=%0d data=%h expected srch=%0d addr=%0d data=%h",
                 bad, obs_q[ld_obs_base + bad].s, obs_q[ld_obs_base + bad].addr,
                 obs_q[ld_obs_base + bad].data, exp_q[bad].s, exp_q[bad].addr, exp_q[bad].data);
      else
        $display("FAIL write_seq at %0d: got no write expected addr=%0d", bad, exp_q[bad].addr);
    end
    n_tests++;
    if (rise_cyc != last_wr_cyc || rise_cyc < ld_cyc_base) begin
      n_fail++;
      $display("FAIL start_align: me_start rose at cycle %0d expected %0d (last srch write)",
               rise_cyc, last_wr_cyc);
    end
    n_tests++;
    if (both_cnt != ld_both_base) begin
      n_fail++;
      $display("FAIL we_overlap: got %0d overlapping cycles expected 0", both_cnt - ld_both_base);
    end
  endtask

  task automatic test_full_load_complete();
    do_load(0, N_LOAD);
    run_phase(int'($urandom_range(200, 1)), 4'hD, 4'h3, 8'h00);
    hold_phase(5);
    check_writes();
  endtask

  task automatic test_gapped_load();
    do_load(1, N_LOAD);
    run_phase(int'($urandom_range(300, 1)), 4'($urandom), 4'($urandom), 8'($urandom));
    hold_phase(int'($urandom_range(4, 0)));
    check_writes();
  endtask

  task automatic test_timeout();
    do_load(2, N_LOAD);
    run_phase(0, 4'h0, 4'h0, 8'h00);
    hold_phase(3);
    check_writes();
  endtask

  task automatic test_complete_at_timeout();
    do_load(2, N_LOAD);
    run_phase(TO, 4'h8, 4'h7, 8'h42);
    hold_phase(2);
  endtask

  task automatic test_midload_reset();
    int rv_base;
    do_load(2, N_REF + 500);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (all_outs() !== 60'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", all_outs());
    end
    repeat (2) @(negedge clock);
    n_tests++;
    if (all_outs() !== 60'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 0", all_outs());
    end
    reset = 1'b1;
    rv_base = rv_cnt;
    @(negedge clock);
    n_tests++;
    if ({in_ready, busy, res_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL midreset_release: ready/busy/valid got %b expected 100",
               {in_ready, busy, res_valid});
    end
    do_load(2, N_LOAD);
    n_tests++;
    if (rv_cnt != rv_base) begin
      n_fail++;
      $display("FAIL stale_result: got %0d res_valid cycles expected 0", rv_cnt - rv_base);
    end
    run_phase(int'($urandom_range(100, 1)), 4'($urandom), 4'($urandom), 8'hFF);
    hold_phase(1);
    check_writes();
  endtask

  task automatic test_random_rounds();
    logic [7:0] bd;
    for (int r = 0; r < 2; r++) begin
      bd = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
      do_load(2, N_LOAD);
      run_phase(int'($urandom_range(300, 1)), 4'($urandom), 4'($urandom), bd);
      hold_phase(int'($urandom_range(3, 0)));
      check_writes();
    end
  endtask

  initial begin
    test_reset();
    test_full_load_complete();
    test_gapped_load();
    test_timeout();
    test_complete_at_timeout();
    test_midload_reset();
    test_random_rounds();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
